truth_table_checker: RTL and testbench



---
 rtl/truth_table_checker.sv | 151 +++++++++++++++
 tb/tb_truth_table_checker.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/truth_table_checker.sv
// truth_table_checker
// Exhaustive stimulus sequencer for a combinational N_IN-input exercise DUT.
// It walks stim through 0 .. 2^N_IN-1 in ascending order. Each vector is held
// for SETTLE cycles and then compared for one CHECK cycle (dut_y vs ref_y).
// The block records the mismatch count, the first failing vector and the
// expected/actual values seen at that first failure.
// Optional build macro: TT_STOP_ON_FAIL_EN. When it is defined, the first
// mismatch ends the run immediately (CHECK -> DONE).
module truth_table_checker #(
    parameter int N_IN   = 3,
    parameter int SETTLE = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    output logic [N_IN-1:0] stim,
    input  logic            dut_y,
    input  logic            ref_y,
    output logic            busy,
    output logic            done,
    output logic            pass,
    output logic [N_IN:0]   fail_cnt,
    output logic [N_IN-1:0] fail_vec,
    output logic            fail_exp,
    output logic            fail_act
);

    // The settle counter only needs to reach SETTLE-1. Its width is at least
    // one bit so that SETTLE=1 still elaborates.
    localparam int CW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(SETTLE - 1);
    // Saturation ceiling for the mismatch counter (2^N_IN).
    localparam logic [N_IN:0] CNT_MAX = {1'b1, {N_IN{1'b0}}};

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SETTLE = 2'd1,
        S_CHECK  = 2'd2,
        S_DONE   = 2'd3
    } state_t;

    state_t          r_state;
    logic [CW-1:0]   r_cnt;
    logic [N_IN-1:0] r_stim;
    logic            r_busy;
    logic            r_done;
    logic            r_pass;
    logic [N_IN:0]   r_fail_cnt;
    logic [N_IN-1:0] r_fail_vec;
    logic            r_fail_exp;
    logic            r_fail_act;

    logic          w_mismatch;
    logic          w_last_vec;
    logic          w_no_fail_yet;
    logic [N_IN:0] w_fail_cnt_inc;
    logic          w_stop;

    // Comparison is 2-state on purpose: only a 0/1 difference counts.
    assign w_mismatch     = dut_y ^ ref_y;
    assign w_last_vec     = &r_stim;
    assign w_no_fail_yet  = (r_fail_cnt == '0);
    assign w_fail_cnt_inc = (r_fail_cnt == CNT_MAX) ? r_fail_cnt
                                                    : r_fail_cnt + 1'b1;

`ifdef TT_STOP_ON_FAIL_EN
    // Abort-on-first-failure: a mismatch in CHECK ends the run.
    assign w_stop = w_mismatch;
`else
    // Full sweep: every vector is applied regardless of earlier failures.
    assign w_stop = 1'b0;
`endif

    // Sequencer FSM and all registered results. Outputs are registered directly.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_cnt      <= '0;
            r_stim     <= '0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_pass     <= 1'b0;
            r_fail_cnt <= '0;
            r_fail_vec <= '0;
            r_fail_exp <= 1'b0;
            r_fail_act <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE, S_DONE: begin
                    // start is only honoured here. Results clear at the start of a new run.
                    if (start) begin
                        r_state    <= S_SETTLE;
                        r_cnt      <= '0;
                        r_stim     <= '0;
                        r_busy     <= 1'b1;
                        r_done     <= 1'b0;
                        r_pass     <= 1'b0;
                        r_fail_cnt <= '0;
                        r_fail_vec <= '0;
                        r_fail_exp <= 1'b0;
                        r_fail_act <= 1'b0;
                    end
                end

                S_SETTLE: begin
                    if (r_cnt == CNT_LAST) begin
                        r_state <= S_CHECK;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end

                S_CHECK: begin
                    if (w_mismatch) begin
                        r_fail_cnt <= w_fail_cnt_inc;
                        if (w_no_fail_yet) begin
                            r_fail_vec <= r_stim;
                            r_fail_exp <= ref_y;
                            r_fail_act <= dut_y;
                        end
                    end
                    if (w_last_vec || w_stop) begin
                        // stim keeps the last vector applied while in DONE.
                        r_state <= S_DONE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_pass  <= w_no_fail_yet && !w_mismatch;
                    end else begin
                        r_state <= S_SETTLE;
                        r_stim  <= r_stim + 1'b1;
                        r_cnt   <= '0;
                    end
                end

                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign stim     = r_stim;
    assign busy     = r_busy;
    assign done     = r_done;
    assign pass     = r_pass;
    assign fail_cnt = r_fail_cnt;
    assign fail_vec = r_fail_vec;
    assign fail_exp = r_fail_exp;
    assign fail_act = r_fail_act;

endmodule

// File: tb/tb_truth_table_checker.sv
// Bench for truth_table_checker.
// The DUT and reference functions are truth-table bytes indexed by stim.
// The model tracks the number of edges since the start edge, and the expected
// outputs follow from that count with plain arithmetic.
module tb_truth_table_checker;

    localparam int N_IN   = 3;
    localparam int SETTLE = 2;
    localparam int NV     = 1 << N_IN;
    localparam int VL     = SETTLE + 1;
    localparam int T_FULL = NV * VL;
    localparam logic [NV-1:0] NAND3   = 8'h7F;
    localparam logic [NV-1:0] STUCK0  = 8'h00;
    localparam logic [NV-1:0] NAND_AB = 8'h3F;

    logic            clk = 1'b0;
    logic            rst;
    logic            start;
    logic [N_IN-1:0] stim;
    logic            dut_y, ref_y, busy, done, pass;
    logic [N_IN:0]   fail_cnt;
    logic [N_IN-1:0] fail_vec;
    logic            fail_exp, fail_act;

    logic [NV-1:0] dut_tt, ref_tt;
    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    assign dut_y = dut_tt[stim];
    assign ref_y = ref_tt[stim];

    truth_table_checker #(.N_IN(N_IN), .SETTLE(SETTLE)) dut (
        .clk(clk), .rst(rst), .start(start), .stim(stim),
        .dut_y(dut_y), .ref_y(ref_y), .busy(busy), .done(done), .pass(pass),
        .fail_cnt(fail_cnt), .fail_vec(fail_vec),
        .fail_exp(fail_exp), .fail_act(fail_act)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    bit            m_run;      // a run has started since reset
    int            m_c;        // edges since the start-sampling edge (frozen once done)
    logic [NV-1:0] m_dut, m_ref;

    function automatic int first_fail();
        for (int v = 0; v < NV; v++)
            if (m_dut[v] != m_ref[v]) return v;
        return -1;
    endfunction

    function automatic int run_len();
`ifdef TT_STOP_ON_FAIL_EN
        int ff;
        ff = first_fail();
        return (ff < 0) ? T_FULL : (ff + 1) * VL;
`else
        return T_FULL;
`endif
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_run = 1'b0;
            m_c   = 0;
        end else if (start && (!m_run || m_c >= run_len())) begin
            m_run = 1'b1;
            m_c   = 0;
            m_dut = dut_tt;
            m_ref = ref_tt;
        end else if (m_run && m_c < run_len()) begin
            m_c++;
        end
    end

    // Compare every cycle, away from the active edge.
    always @(negedge clk) begin
        int len, chk, cnt, first;
        int e_stim, e_busy, e_done, e_pass;
        e_stim = 0; e_busy = 0; e_done = 0; e_pass = 0; chk = 0; cnt = 0; first = -1;
        if (m_run) begin
            len = run_len();
            if (m_c < len) begin
                e_busy = 1;
                e_stim = m_c / VL;
                chk    = m_c / VL;
            end else begin
                e_done = 1;
                chk    = len / VL;
                e_stim = chk - 1;
            end
            for (int v = 0; v < chk; v++) begin
                if (m_dut[v] != m_ref[v]) begin
                    if (first < 0) first = v;
                    cnt++;
                end
            end
            if (e_done == 1) e_pass = (cnt == 0) ? 1 : 0;
        end
        check("stim", stim, e_stim);
        check("busy", busy, e_busy);
        check("done", done, e_done);
        check("pass", pass, e_pass);
        check("fail_cnt", fail_cnt, cnt);
        check("fail_vec", fail_vec, (first < 0) ? 0 : first);
        check("fail_exp", fail_exp, (first < 0) ? 0 : m_ref[first]);
        check("fail_act", fail_act, (first < 0) ? 0 : m_dut[first]);
    end

    // ---------------- stimulus ----------------
    // Waits (bounded) for done; optionally pokes start once while busy.
    task automatic wait_done(input int poke, output int n);
        n = 0;
        while (!done && n < 1000) begin
            @(posedge clk);
            n++;
            #1;
            start = (n == poke) && busy;
        end
        start = 1'b0;
        check("done_seen", done, 1);
    endtask

    task automatic run_tt(input logic [NV-1:0] tt, input int poke, output int n);
        @(negedge clk);
        dut_tt = tt;
        start  = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        wait_done(poke, n);
        @(negedge clk);
        $display("run tt=%02h done_at=%0d fail_cnt=%0d fail_vec=%0d exp=%0d act=%0d pass=%0d",
                 tt, n, fail_cnt, fail_vec, fail_exp, fail_act, pass);
    endtask

    initial begin
        int n;
        rst    = 1'b1;
        start  = 1'b0;
        dut_tt = NAND3;
        ref_tt = NAND3;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // Correct DUT.
        run_tt(NAND3, -1, n);
        check("nand3_done_at", n, 24);
        check("nand3_pass", pass, 1);
        check("nand3_fail_cnt", fail_cnt, 0);
        check("nand3_fail_vec", fail_vec, 0);

        // Stuck-at-0 DUT.
        run_tt(STUCK0, -1, n);
`ifdef TT_STOP_ON_FAIL_EN
        check("sa0_done_at", n, 3);
        check("sa0_fail_cnt", fail_cnt, 1);
        check("sa0_stim", stim, 0);
`else
        check("sa0_done_at", n, 24);
        check("sa0_fail_cnt", fail_cnt, 7);
`endif
        check("sa0_fail_vec", fail_vec, 0);
        check("sa0_fail_exp", fail_exp, 1);
        check("sa0_fail_act", fail_act, 0);
        check("sa0_pass", pass, 0);

        // nand(a,b) ignoring c: only vector 110 differs.
        run_tt(NAND_AB, -1, n);
`ifdef TT_STOP_ON_FAIL_EN
        check("nab_done_at", n, 21);
`else
        check("nab_done_at", n, 24);
`endif
        check("nab_fail_cnt", fail_cnt, 1);
        check("nab_fail_vec", fail_vec, 3'b110);
        check("nab_fail_exp", fail_exp, 1);
        check("nab_fail_act", fail_act, 0);

        // start poked mid-run is ignored; then a restart from DONE.
        run_tt(NAND3, 10, n);
        check("poke_done_at", n, 24);
        run_tt(NAND3, -1, n);
        check("restart_done_at", n, 24);

        // start held high: DONE lasts one cycle.
        start = 1'b1;
        @(posedge clk);
        #1;
        n = 0;
        while (!done && n < 1000) begin
            @(posedge clk);
            n++;
            #1;
        end
        check("held_done_at", n, 24);
        @(posedge clk);
        #1;
        check("held_done_drop", done, 0);
        check("held_busy_rise", busy, 1);
        start = 1'b0;
        wait_done(-1, n);
        check("held_second_done_at", n, 24);
        @(negedge clk);

        // Asynchronous reset between edges during a run.
        dut_tt = STUCK0;
        start  = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (12) @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        check("rst_stim", stim, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_fail_cnt", fail_cnt, 0);
        check("rst_fail_vec", fail_vec, 0);
        @(negedge clk);
        rst = 1'b0;
        run_tt(NAND3, -1, n);
        check("post_rst_done_at", n, 24);
        check("post_rst_pass", pass, 1);

        // Randomised truth tables and mid-run start pokes.
        for (int k = 0; k < 10; k++) begin
            run_tt(NV'($urandom), int'($urandom_range(1, 22)), n);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
